// File: rtl/fifo_wr_mem_if.sv
// Write-side handshake bundle of the async FIFO write half: data/request in, status flags out.
interface fifo_wr_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic [DATA_W-1:0] W_DATA;
    logic              W_INC;
    logic              W_OVF_CLR;
    logic              W_FULL;
    logic              W_AFULL;
    logic [ADDR_W:0]   W_LEVEL;
    logic              W_OVF;

    modport master (
        output W_DATA,
        output W_INC,
        output W_OVF_CLR,
        input  W_FULL,
        input  W_AFULL,
        input  W_LEVEL,
        input  W_OVF
    );

    modport slave (
        input  W_DATA,
        input  W_INC,
        input  W_OVF_CLR,
        output W_FULL,
        output W_AFULL,
        output W_LEVEL,
        output W_OVF
    );
endinterface

// File: rtl/fifo_wr_mem.sv
// Write-domain half of the async FIFO: storage, write pointer, full/afull/level/overflow flags.
// Optional per-word even parity with R_PERR output when FIFO_WR_PARITY_EN is defined.
module fifo_wr_mem #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int AFULL_TH = 6
) (
    input  logic              W_CLK,
    input  logic              W_RST,
    fifo_wr_mem_if.slave      wr,
    input  logic [ADDR_W:0]   W_RPTR_GRAY_SYNC,
    output logic [ADDR_W:0]   W_PTR_GRAY,
    input  logic [ADDR_W-1:0] R_ADDR,
    output logic [DATA_W-1:0] R_DATA
`ifdef FIFO_WR_PARITY_EN
    ,
    output logic              R_PERR
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] AFULL_LVL = AFULL_TH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef FIFO_WR_PARITY_EN
    logic              par [DEPTH];
`endif

    logic [ADDR_W:0] wptr_bin;
    logic [ADDR_W:0] wptr_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] rptr_bin;
    logic [ADDR_W:0] full_cmp;
    logic [ADDR_W:0] level_next;
    logic            wr_en;

    logic            full_q;
    logic            afull_q;
    logic [ADDR_W:0] level_q;
    logic            ovf_q;

    assign wr_en      = wr.W_INC & ~full_q;
    assign wptr_next  = wptr_bin + {{ADDR_W{1'b0}}, wr_en};
    assign wgray_next = wptr_next ^ (wptr_next >> 1);
    assign level_next = wptr_next - rptr_bin;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rptr_bin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rptr_bin[i] = ^(W_RPTR_GRAY_SYNC >> i);
        end
    end

    generate
        if (ADDR_W == 1) begin : g_full_narrow
            assign full_cmp = ~W_RPTR_GRAY_SYNC;
        end else begin : g_full_wide
            assign full_cmp = {~W_RPTR_GRAY_SYNC[ADDR_W:ADDR_W-1], W_RPTR_GRAY_SYNC[ADDR_W-2:0]};
        end
    endgenerate

    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
`ifdef FIFO_WR_PARITY_EN
                par[i] <= 1'b0;
`endif
            end
        end else if (wr_en) begin
            mem[wptr_bin[ADDR_W-1:0]] <= wr.W_DATA;
`ifdef FIFO_WR_PARITY_EN
            par[wptr_bin[ADDR_W-1:0]] <= ^wr.W_DATA;
`endif
        end
    end

    // Flags are recomputed every edge so a read-side free is seen even without a write.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            wptr_bin   <= '0;
            W_PTR_GRAY <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wptr_bin   <= wptr_next;
            W_PTR_GRAY <= wgray_next;
            full_q     <= (wgray_next == full_cmp);
            afull_q    <= (level_next >= AFULL_LVL);
            level_q    <= level_next;
            if (wr.W_INC && full_q) begin
                ovf_q <= 1'b1;
            end else if (wr.W_OVF_CLR) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign wr.W_FULL  = full_q;
    assign wr.W_AFULL = afull_q;
    assign wr.W_LEVEL = level_q;
    assign wr.W_OVF   = ovf_q;

    assign R_DATA = mem[R_ADDR];
`ifdef FIFO_WR_PARITY_EN
    assign R_PERR = ^{par[R_ADDR], mem[R_ADDR]};
`endif

endmodule

// File: doc/fifo_wr_mem.md
Name: fifo_wr_mem

Overview:
- Write-domain half of the async FIFO: storage array plus write pointer, full/almost-full/level flags and overflow detection, all in the W_CLK domain.
- Consumes the read-domain Gray pointer, already synchronised into W_CLK by the existing 2-flop synchroniser.
- Exports a registered Gray write pointer for synchronisation into the read domain.
- Read data is combinational by read address, for use by the read-side block.

Parameters:
- DATA_W, 8, width of each stored word.
- ADDR_W, 3, address width. Depth = 2**ADDR_W. Pointers are ADDR_W+1 bits wide.
- AFULL_TH, 6, level at or above which W_AFULL asserts. Legal range 1..2**ADDR_W.

Ports:
- W_CLK  in  1  write clock.
- W_RST  in  1  asynchronous, active-low reset.
- W_DATA  in  DATA_W  write data.
- W_INC  in  1  write request.
- W_RPTR_GRAY_SYNC  in  ADDR_W+1  read pointer, Gray-coded, already synchronised to W_CLK.
- W_OVF_CLR  in  1  clears the sticky overflow flag.
- W_FULL  out  1  FIFO full, registered.
- W_AFULL  out  1  level >= AFULL_TH, registered.
- W_LEVEL  out  ADDR_W+1  occupancy as seen from the write side, registered.
- W_OVF  out  1  sticky overflow error.
- W_PTR_GRAY  out  ADDR_W+1  write pointer, Gray-coded, registered.
- R_ADDR  in  ADDR_W  read address from the read-side block.
- R_DATA  out  DATA_W  combinational: mem[R_ADDR].

Behaviour:
- Reset (W_RST low, asynchronous):
  - All memory words = 0.
  - Binary write pointer = 0; W_PTR_GRAY = 0.
  - W_FULL = 0, W_AFULL = 0, W_LEVEL = 0, W_OVF = 0.
  - Release is synchronous to the next W_CLK edge.
- Write accept: wr_en = W_INC & ~W_FULL.
  - On an accepting edge: mem[wptr_bin[ADDR_W-1:0]] <= W_DATA, then wptr_bin increments by 1.
  - Pointer wraps modulo 2**(ADDR_W+1).
- Gray encoding: W_PTR_GRAY <= wptr_next ^ (wptr_next >> 1). Registered; exactly one bit changes per accepted write.
- Read pointer conversion: rptr_bin is decoded combinationally from W_RPTR_GRAY_SYNC by prefix XOR from the MSB down.
- Full: W_FULL <= (gray(wptr_next) == {~rgray[ADDR_W:ADDR_W-1], rgray[ADDR_W-2:0]}).
  - The write that fills the last slot asserts W_FULL on the same edge. There is no extra-cycle latency.
  - W_FULL deasserts on the first edge after W_RPTR_GRAY_SYNC advances.
  - For ADDR_W = 1, the comparison is on the inverted top two bits only.
- Level: W_LEVEL <= wptr_next - rptr_bin, computed modulo 2**(ADDR_W+1).
  - Range is 0..2**ADDR_W.
  - Pessimistic: it lags read-side frees by the synchroniser delay.
- Almost full: W_AFULL <= (wptr_next - rptr_bin) >= AFULL_TH. Same timing as W_LEVEL.
- Overflow:
  - W_INC & W_FULL on an edge sets W_OVF.
  - W_OVF_CLR clears W_OVF.
  - Set wins when set and clear occur on the same edge.
  - A rejected write leaves the memory, pointers and flags unchanged.
- Read port:
  - R_DATA = mem[R_ADDR], with no clock.
  - A write to the address currently on R_ADDR shows the old data until the write edge and the new data after it.
- Wrap-around: after 2**ADDR_W writes the address field returns to 0 while the pointer MSB toggles. Full/empty comparisons depend on that MSB.
- Reset mid-operation:
  - All state returns to its reset values immediately.
  - A W_INC present during reset is ignored.
  - The read domain must be reset together with the write domain. Pointer coherency is otherwise undefined.

Optional Feature:
- Macro: FIFO_WR_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, ^W_DATA, written together with the data.
  - Extra output R_PERR (1 bit), combinational: ^{stored parity, mem[R_ADDR]}.
  - Reset clears the parity bits to 0, which is consistent with the all-zero data.
- When undefined:
  - No parity storage and no R_PERR port.
  - All other behaviour is identical.

Test Plan (DATA_W = 8, ADDR_W = 3, AFULL_TH = 6):
- Reset check: assert W_RST with W_INC = 1 -> W_FULL = 0, W_AFULL = 0, W_LEVEL = 0, W_OVF = 0, W_PTR_GRAY = 0, R_DATA = 0 for every R_ADDR.
- Fill from empty:
  - Stimulus: rptr held at 0; write 0x11..0x88 on consecutive edges.
  - W_LEVEL steps 1..8.
  - W_AFULL asserts on the 6th write edge.
  - W_FULL asserts on the 8th write edge.
  - W_PTR_GRAY sequence: 1, 3, 2, 6, 7, 5, 4, C.
  - R_ADDR = 0..7 reads back 0x11..0x88.
- Overflow:
  - Stimulus: write 0xFF while full.
  - Memory and pointer are unchanged, and W_OVF = 1.
  - W_OVF_CLR pulse -> W_OVF = 0.
  - W_OVF_CLR together with a new rejected write -> W_OVF stays 1.
- Free and wrap:
  - Stimulus: while full, drive W_RPTR_GRAY_SYNC = 1; then write 0x99.
  - The first edge after the pointer change gives W_FULL = 0 and W_LEVEL = 7.
  - The write of 0x99 lands in address 0, and W_PTR_GRAY = 0xD (binary 9).
  - W_FULL reasserts on that edge.
- Simultaneous read/write: hold R_ADDR = 2 while writing address 2 with 0x5A -> R_DATA changes from its old value to 0x5A only after the write edge.
- Parity (FIFO_WR_PARITY_EN defined):
  - Write 0x07 -> R_PERR = 0 at that address.
  - Force-flip one stored data bit -> R_PERR = 1.
